// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand : iterative AES-128 key schedule, one round key per clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_valid,
  output logic                            key_ready,
  input  logic [0:127]                    key_in,
  input  logic                            sched_lock,
  output logic                            busy,
  output logic                            sched_valid,
  output logic [0:128*(NUM_ROUNDS+1)-1]   key_schedule
);

  generate
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_key_expand supports only NUM_ROUNDS = 10");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         accept;
  logic [127:0] slot_q [0:10];
  logic [3:0]   cnt_q;
  logic [7:0]   rcon_q;
  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    key_ready = (state_q != EXPAND) && !sched_lock;
    accept    = key_valid && key_ready;
    case (state_q)
      IDLE, DONE: if (accept) state_d = EXPAND;
      EXPAND:     if (cnt_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == EXPAND);
  assign sched_valid = (state_q == DONE);

  // cnt is 0 only in IDLE, where the datapath result is unused
  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev     = slot_q[prev_idx];
  assign w0       = prev[127:96];
  assign w1       = prev[95:64];
  assign w2       = prev[63:32];
  assign w3       = prev[31:0];
  assign rot      = {w3[23:0], w3[31:24]};
  assign sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign t        = sub ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) slot_q[i] <= '0;
      cnt_q  <= 4'd0;
      rcon_q <= 8'h01;
    end else if (accept) begin
      slot_q[0] <= key_in;
      cnt_q     <= 4'd1;
      rcon_q    <= 8'h01;
    end else if (state_q == EXPAND) begin
      slot_q[cnt_q] <= {n0, n1, n2, n3};
      cnt_q         <= (cnt_q == LAST) ? cnt_q : cnt_q + 4'd1;
      rcon_q        <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  generate
    for (genvar r = 0; r <= NUM_ROUNDS; r++) begin : g_slot
      assign key_schedule[r*128 +: 128] = slot_q[r];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand: FIPS-197 vectors, random keys against a word-recursion model,
// and the lock / ignore / mid-expansion reset corner cases.
`default_nettype none

module tb_aes_key_expand;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic          key_ready;
  logic [0:127]  key_in = '0;
  logic          sched_lock = 1'b0;
  logic          busy;
  logic          sched_valid;
  logic [0:1407] key_schedule;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox_m [256];

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_in       (key_in),
    .sched_lock   (sched_lock),
    .busy         (busy),
    .sched_valid  (sched_valid),
    .key_schedule (key_schedule)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] v, int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [0:1407] model(logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] rk_of(logic [0:1407] s, int r);
    return s[r*128 +: 128];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_sched(input string tag, input logic [0:1407] exp);
    for (int r = 0; r <= 10; r++)
      check($sformatf("%s rk%0d", tag, r), rk_of(key_schedule, r), rk_of(exp, r));
  endtask

  task automatic wait_done(input string tag, input int start);
    int lat = start;
    while (!sched_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " busy_done"}, 128'(busy), 128'd0);
  endtask

  task automatic run_key(input logic [127:0] k, input string tag);
    key_in    = k;
    key_valid = 1'b1;
    #1;
    check({tag, " key_ready"}, 128'(key_ready), 128'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check({tag, " busy_accept"}, 128'(busy), 128'd1);
    check({tag, " valid_accept"}, 128'(sched_valid), 128'd0);
    wait_done(tag, 0);
    check_sched(tag, model(k));
  endtask

  initial begin
    vec_t vecs [2];
    logic [127:0]  ka, kb;
    logic [0:1407] held;

    build_sbox();
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                rk1: 128'ha0fafe1788542cb123a339392a6c7605,
                rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{key: 128'h0,
                rk1: 128'h62636363626363636263636362636363,
                rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // reset state
    #12;
    check("reset busy", 128'(busy), 128'd0);
    check("reset sched_valid", 128'(sched_valid), 128'd0);
    check_sched("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release key_ready", 128'(key_ready), 128'd1);
    check("release sched_valid", 128'(sched_valid), 128'd0);

    // known-answer table
    for (int v = 0; v < 2; v++) begin
      run_key(vecs[v].key, $sformatf("vec%0d", v));
      check($sformatf("vec%0d rk1 kat", v), rk_of(key_schedule, 1), vecs[v].rk1);
      check($sformatf("vec%0d rk10 kat", v), rk_of(key_schedule, 10), vecs[v].rk10);
    end

    // random keys
    for (int n = 0; n < 6; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      run_key(ka, $sformatf("rand%0d", n));
    end

    // key offered during expansion is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    key_in = ka; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    key_in = kb; key_valid = 1'b1;
    #1;
    check("ignore key_ready", 128'(key_ready), 128'd0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_done("ignore", 4);
    check_sched("ignore", model(ka));

    // lock held in DONE blocks acceptance, release accepts the same cycle
    held = model(ka);
    kb = {$urandom, $urandom, $urandom, $urandom};
    key_in = kb; key_valid = 1'b1; sched_lock = 1'b1;
    #1;
    check("lock key_ready", 128'(key_ready), 128'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("lock valid c%0d", c), 128'(sched_valid), 128'd1);
      check($sformatf("lock ready c%0d", c), 128'(key_ready), 128'd0);
    end
    check_sched("lock held", held);
    sched_lock = 1'b0;
    #1;
    check("unlock key_ready", 128'(key_ready), 128'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("unlock valid drop", 128'(sched_valid), 128'd0);
    check("unlock busy", 128'(busy), 128'd1);
    wait_done("unlock", 0);
    check_sched("unlock", model(kb));

    // asynchronous reset in the middle of an expansion
    ka = {$urandom, $urandom, $urandom, $urandom};
    key_in = ka; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst sched_valid", 128'(sched_valid), 128'd0);
    check_sched("midrst", '0);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst key_ready", 128'(key_ready), 128'd1);
    run_key(vecs[0].key, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
